// File: rtl/sys_led_monitor_if.sv
// Debug-display bus for sys_led_monitor: channel taps and controls in, LED drive out.
// master = the side driving the channel taps and controls, slave = the display unit.
interface sys_led_monitor_if #(
    parameter int unsigned NUM_CH = 8,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned LED_W  = 27
);
    localparam int unsigned SEL_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic [SEL_W-1:0]         SYS_output_sel;
    logic [NUM_CH*DATA_W-1:0] ch_data;
    logic [1:0]               mode;
    logic                     freeze_trig;
    logic [LED_W-1:0]         SYS_leds;
    logic                     CLK_led;
    logic [SEL_W-1:0]         cur_ch;
    logic                     frozen;

    modport master (
        output SYS_output_sel, ch_data, mode, freeze_trig,
        input  SYS_leds, CLK_led, cur_ch, frozen
    );

    modport slave (
        input  SYS_output_sel, ch_data, mode, freeze_trig,
        output SYS_leds, CLK_led, cur_ch, frozen
    );
endinterface

// File: rtl/sys_led_monitor.sv
// Debug display unit: direct / auto-scan / freeze views of NUM_CH debug words on the board LEDs.
// Optional macro LED_CH_TAG_EN puts the displayed channel index in the top SEL_W LED bits.
module sys_led_monitor #(
    parameter int unsigned NUM_CH    = 8,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned LED_W     = 27,
    parameter int unsigned DIV_CNT   = 25000000,
    parameter int unsigned SCAN_HOLD = 4
) (
    input  logic                clk,
    input  logic                SYS_reset,
    sys_led_monitor_if.slave    bus
);
    localparam int unsigned SEL_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int unsigned DIV_W    = (DIV_CNT > 1) ? $clog2(DIV_CNT) : 1;
    localparam int unsigned HOLD_W   = (SCAN_HOLD > 1) ? $clog2(SCAN_HOLD) : 1;
    localparam int unsigned TAG_LO_W = LED_W - SEL_W;

    typedef enum logic [1:0] {
        MODE_DIRECT     = 2'b00,
        MODE_SCAN       = 2'b01,
        MODE_FREEZE     = 2'b10,
        MODE_DIRECT_ALT = 2'b11
    } mode_t;

    typedef enum logic {
        FRZ_ARMED = 1'b0,
        FRZ_HELD  = 1'b1
    } frz_state_t;

    frz_state_t         frz_state;
    logic [DIV_W-1:0]   div_cnt;
    logic [HOLD_W-1:0]  scan_cnt;
    logic [SEL_W-1:0]   cur_ch;
    logic [LED_W-1:0]   sys_leds;
    logic               clk_led;
    logic               frozen;
    logic [DATA_W-1:0]  snapshot;

    logic               tick_c;
    mode_t              mode_c;
    logic [SEL_W-1:0]   scan_base_c;
    logic [SEL_W-1:0]   show_idx_c;
    logic [HOLD_W-1:0]  scan_cnt_nxt_c;
    logic               hold_view_c;
    logic [DATA_W-1:0]  sel_word_c;
    logic [DATA_W-1:0]  word_c;
    logic [LED_W-1:0]   led_c;

    // Channel mux; an index past the last channel reads as zero.
    function automatic logic [DATA_W-1:0] pick_word(
        input logic [SEL_W-1:0]         idx,
        input logic [NUM_CH*DATA_W-1:0] flat
    );
        logic [DATA_W-1:0] w;
        w = '0;
        for (int k = 0; k < int'(NUM_CH); k++) begin
            if (idx == SEL_W'(k)) begin
                w = flat[k*DATA_W +: DATA_W];
            end
        end
        return w;
    endfunction

    assign tick_c      = (div_cnt == DIV_W'(DIV_CNT - 1));
    assign mode_c      = mode_t'(bus.mode);
    assign sel_word_c  = pick_word(bus.SYS_output_sel, bus.ch_data);
    assign scan_base_c = (32'(cur_ch) >= NUM_CH) ? '0 : cur_ch;

    // Next displayed channel and scan dwell count for the current mode.
    always_comb begin
        show_idx_c     = bus.SYS_output_sel;
        scan_cnt_nxt_c = '0;
        hold_view_c    = 1'b0;
        case (mode_c)
            MODE_SCAN: begin
                show_idx_c     = scan_base_c;
                scan_cnt_nxt_c = scan_cnt;
                if (tick_c) begin
                    if (scan_cnt == HOLD_W'(SCAN_HOLD - 1)) begin
                        scan_cnt_nxt_c = '0;
                        show_idx_c     = (32'(scan_base_c) == NUM_CH - 1) ? '0
                                                                          : scan_base_c + 1'b1;
                    end else begin
                        scan_cnt_nxt_c = scan_cnt + 1'b1;
                    end
                end
            end
            MODE_FREEZE: begin
                if (frz_state == FRZ_HELD) begin
                    show_idx_c  = cur_ch;
                    hold_view_c = 1'b1;
                end
            end
            default: begin
                show_idx_c = bus.SYS_output_sel;
            end
        endcase
    end

    // Word to display: the snapshot while held, otherwise the live tap of the shown channel.
    always_comb begin
        word_c = '0;
        if (hold_view_c) begin
            word_c = snapshot;
        end else if (mode_c == MODE_SCAN) begin
            word_c = pick_word(show_idx_c, bus.ch_data);
        end else begin
            word_c = sel_word_c;
        end
    end

`ifdef LED_CH_TAG_EN
    assign led_c = {show_idx_c, TAG_LO_W'(word_c)};
`else
    assign led_c = LED_W'(word_c);
`endif

    // Heartbeat, display registers and freeze FSM.
    always_ff @(posedge clk) begin
        if (!SYS_reset) begin
            frz_state <= FRZ_ARMED;
            div_cnt   <= '0;
            scan_cnt  <= '0;
            cur_ch    <= '0;
            sys_leds  <= '0;
            clk_led   <= 1'b0;
            frozen    <= 1'b0;
            snapshot  <= '0;
        end else begin
            div_cnt  <= tick_c ? '0 : div_cnt + 1'b1;
            if (tick_c) begin
                clk_led <= ~clk_led;
            end
            scan_cnt <= scan_cnt_nxt_c;
            cur_ch   <= show_idx_c;
            sys_leds <= led_c;

            case (frz_state)
                FRZ_ARMED: begin
                    if (mode_c == MODE_FREEZE && bus.freeze_trig) begin
                        snapshot  <= sel_word_c;
                        frozen    <= 1'b1;
                        frz_state <= FRZ_HELD;
                    end
                end
                FRZ_HELD: begin
                    if (mode_c != MODE_FREEZE) begin
                        frozen    <= 1'b0;
                        frz_state <= FRZ_ARMED;
                    end
                end
                default: begin
                    frozen    <= 1'b0;
                    frz_state <= FRZ_ARMED;
                end
            endcase
        end
    end

    assign bus.SYS_leds = sys_leds;
    assign bus.CLK_led  = clk_led;
    assign bus.cur_ch   = cur_ch;
    assign bus.frozen   = frozen;
endmodule

// File: tb/tb_sys_led_monitor.sv
// Bench for sys_led_monitor: directed scenarios plus random traffic against a cycle-count model.
module tb_sys_led_monitor;
    localparam int NUM_CH    = 8;
    localparam int DATA_W    = 32;
    localparam int LED_W     = 27;
    localparam int DIV_CNT   = 4;
    localparam int SCAN_HOLD = 2;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    sys_led_monitor_if #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .LED_W(LED_W)) bus ();

    sys_led_monitor #(
        .NUM_CH(NUM_CH), .DATA_W(DATA_W), .LED_W(LED_W),
        .DIV_CNT(DIV_CNT), .SCAN_HOLD(SCAN_HOLD)
    ) dut (
        .clk(clk),
        .SYS_reset(rst_n),
        .bus(bus)
    );

    logic [31:0] chv [NUM_CH];
    logic [2:0]  sel;
    logic [1:0]  mode;
    logic        trig;

    int vectors = 0;
    int miscompares = 0;

    // Reference state: time since reset, scan dwell ticks, shown channel, snapshot.
    int          m_cyc;
    int          m_ticks;
    int          m_cur;
    logic [26:0] m_leds;
    logic        m_clk;
    logic        m_held;
    logic [31:0] m_snap;

    function automatic logic [26:0] led_of(input int idx, input logic [31:0] w);
`ifdef LED_CH_TAG_EN
        logic [2:0] i3;
        i3 = 3'(idx);
        return {i3, w[23:0]};
`else
        return w[26:0];
`endif
    endfunction

    task automatic drive();
        for (int k = 0; k < NUM_CH; k++) bus.ch_data[k*DATA_W +: DATA_W] = chv[k];
        bus.SYS_output_sel = sel;
        bus.mode           = mode;
        bus.freeze_trig    = trig;
    endtask

    task automatic model_edge();
        logic [31:0] w;
        bit tick;
        if (!rst_n) begin
            m_cyc = 0; m_ticks = 0; m_cur = 0; m_leds = '0;
            m_clk = 0; m_held = 0; m_snap = '0;
        end else begin
            tick = ((m_cyc % DIV_CNT) == DIV_CNT - 1);
            if (mode == 2'b01) begin
                if (m_cur >= NUM_CH) m_cur = 0;
                if (tick) begin
                    m_ticks++;
                    if (m_ticks == SCAN_HOLD) begin
                        m_ticks = 0;
                        m_cur = (m_cur + 1) % NUM_CH;
                    end
                end
                w = chv[m_cur];
            end else if (mode == 2'b10 && m_held) begin
                w = m_snap;
            end else begin
                m_ticks = 0;
                m_cur = int'(sel);
                w = (m_cur < NUM_CH) ? chv[m_cur] : 32'h0;
                if (mode == 2'b10 && trig) begin
                    m_snap = w;
                    m_held = 1;
                end
            end
            if (mode != 2'b10) m_held = 0;
            m_leds = led_of(m_cur, w);
            if (tick) m_clk = ~m_clk;
            m_cyc++;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        drive();
        @(posedge clk);
        model_edge();
        #1;
        check("leds",   32'(bus.SYS_leds), 32'(m_leds));
        check("clk_led", 32'(bus.CLK_led), 32'(m_clk));
        check("cur_ch", 32'(bus.cur_ch),   32'(m_cur));
        check("frozen", 32'(bus.frozen),   32'(m_held));
    endtask

    initial begin
        int t7;
        int t0;
        int tr;
        for (int k = 0; k < NUM_CH; k++) chv[k] = 32'hA000_0000 + 32'(k);
        sel = 3'd0; mode = 2'b00; trig = 1'b0; rst_n = 1'b0;
        drive();

        // Reset for 3 edges
        repeat (3) step();
        check("rst_leds",   32'(bus.SYS_leds), 32'h0);
        check("rst_clkled", 32'(bus.CLK_led),  32'h0);
        check("rst_cur",    32'(bus.cur_ch),   32'h0);
        check("rst_frozen", 32'(bus.frozen),   32'h0);

        // Heartbeat: first rise on 4th edge after release, then every 4
        rst_n = 1'b1;
        repeat (3) step();
        check("hb_low3", 32'(bus.CLK_led), 32'h0);
        step();
        check("hb_rise4", 32'(bus.CLK_led), 32'h1);
        repeat (4) step();
        check("hb_fall8", 32'(bus.CLK_led), 32'h0);

        // Direct mode
        sel = 3'd2;
        step();
        check("dir_leds", 32'(bus.SYS_leds), 32'(led_of(2, 32'hA000_0002)));
        check("dir_cur",  32'(bus.cur_ch),   32'd2);
        chv[2] = 32'h07FF_FFFF;
        step();
        check("dir_live", 32'(bus.SYS_leds), 32'(led_of(2, 32'h07FF_FFFF)));

        // Scan from channel 6: 7 then 0 exactly 8 cycles apart
        sel = 3'd6;
        step();
        mode = 2'b01;
        t7 = -1;
        for (int i = 1; i <= 12 && t7 < 0; i++) begin
            step();
            if (bus.cur_ch == 3'd7) t7 = i;
        end
        check("scan_to7_seen", 32'(t7 > 0 && t7 <= 8), 32'h1);
        t0 = -1;
        for (int i = 1; i <= 12 && t0 < 0; i++) begin
            step();
            if (bus.cur_ch == 3'd0) t0 = i;
        end
        check("scan_wrap_gap", 32'(t0), 32'd8);
        check("scan_wrap_leds", 32'(bus.SYS_leds), 32'(led_of(0, 32'hA000_0000)));

        // Freeze: capture channel 3, then mutate it
        mode = 2'b10; sel = 3'd3;
        step();
        trig = 1'b1;
        step();
        trig = 1'b0;
        chv[3] = 32'h1234_5678;
        repeat (2) step();
        check("frz_leds",   32'(bus.SYS_leds), 32'(led_of(3, 32'hA000_0003)));
        check("frz_flag",   32'(bus.frozen),   32'h1);
        sel = 3'd5; trig = 1'b1;
        step();
        trig = 1'b0;
        step();
        check("frz_retrig_cur",  32'(bus.cur_ch),   32'd3);
        check("frz_retrig_leds", 32'(bus.SYS_leds), 32'(led_of(3, 32'hA000_0003)));
        sel = 3'd3; mode = 2'b00;
        step();
        check("unfrz_flag", 32'(bus.frozen),   32'h0);
        check("unfrz_leds", 32'(bus.SYS_leds), 32'(led_of(3, 32'h1234_5678)));

        // Mid-scan reset at channel 5
        mode = 2'b01;
        tr = 0;
        for (int i = 0; i < 80 && tr == 0; i++) begin
            step();
            if (bus.cur_ch == 3'd5) tr = 1;
        end
        check("scan_reach5", 32'(tr), 32'h1);
        rst_n = 1'b0;
        step();
        check("mrst_leds",   32'(bus.SYS_leds), 32'h0);
        check("mrst_cur",    32'(bus.cur_ch),   32'h0);
        check("mrst_clkled", 32'(bus.CLK_led),  32'h0);
        check("mrst_frozen", 32'(bus.frozen),   32'h0);
        rst_n = 1'b1;
        step();
        check("mrst_restart", 32'(bus.cur_ch), 32'h0);
        repeat (8) step();
        check("mrst_next", 32'(bus.cur_ch), 32'd1);

        // Direct sel=5 (tag field carries 5 when the tag option is built in)
        mode = 2'b00; sel = 3'd5; chv[5] = 32'hA000_0005;
        step();
        check("tag_leds", 32'(bus.SYS_leds), 32'(led_of(5, 32'hA000_0005)));

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 5) == 0) mode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 2) == 0) sel = 3'($urandom_range(0, 7));
            trig  = ($urandom_range(0, 7) == 0);
            rst_n = ($urandom_range(0, 49) != 0);
            if ($urandom_range(0, 3) == 0) chv[$urandom_range(0, NUM_CH - 1)] = $urandom;
            step();
        end
        rst_n = 1'b1; trig = 1'b0;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/sys_led_monitor.md
Name: sys_led_monitor

Overview:
- Parametrised debug display unit that replaces the fixed output-select path in `system`.
- Takes NUM_CH packed debug words (register-file taps, PC, ALU result, etc.) and drives SYS_leds and CLK_led.
- Adds three selectable modes: direct select, auto-scan across channels, and triggered freeze/snapshot.
- Sits between the CPU datapath debug taps and the board LEDs.

Parameters:
- NUM_CH, 8, number of debug channels (2..64).
- DATA_W, 32, width of each channel word.
- LED_W, 27, width of SYS_leds.
- DIV_CNT, 25000000, clk cycles per CLK_led half-period (>=2).
- SCAN_HOLD, 4, ticks each channel is shown in scan mode (>=1).
- SEL_W, derived = max(1, clog2(NUM_CH)); not user-set.

Ports:
- clk  in  1  system clock.
- SYS_reset  in  1  reset, synchronous, active-low.
- SYS_output_sel  in  SEL_W  channel index for direct mode.
- ch_data  in  NUM_CH*DATA_W  packed channel words; channel k = bits [k*DATA_W +: DATA_W].
- mode  in  2  00 direct, 01 scan, 10 freeze, 11 treated as direct.
- freeze_trig  in  1  single-cycle capture request in freeze mode.
- SYS_leds  out  LED_W  displayed value, registered.
- CLK_led  out  1  divided heartbeat, registered.
- cur_ch  out  SEL_W  channel currently displayed, registered.
- frozen  out  1  high while a snapshot is being held.

Behaviour:
- Reset: sampled on clk rising edge when SYS_reset=0. Clears div counter, scan counter, SYS_leds, CLK_led, cur_ch, frozen and snapshot to 0. Applies mid-operation in any mode with identical result.
- Tick generator:
  - div_cnt counts 0..DIV_CNT-1, then wraps to 0.
  - tick = (div_cnt==DIV_CNT-1).
  - CLK_led toggles on tick, giving period 2*DIV_CNT.
- Format function fmt(w):
  - DATA_W>=LED_W: w[LED_W-1:0].
  - Otherwise: w zero-extended to LED_W.
- Direct mode (00/11):
  - cur_ch <= SYS_output_sel each cycle.
  - SYS_leds <= fmt(ch_data[SYS_output_sel]), i.e. 1-cycle latency from sel/data to LEDs.
  - If SYS_output_sel >= NUM_CH: SYS_leds <= 0 and cur_ch <= SYS_output_sel.
  - scan_cnt held at 0.
- Scan mode (01):
  - On entry, scanning starts from the current cur_ch. If cur_ch >= NUM_CH, cur_ch is forced to 0 on the entry cycle.
  - scan_cnt increments on each tick. When a tick arrives with scan_cnt==SCAN_HOLD-1: scan_cnt<=0 and cur_ch<=cur_ch+1, wrapping from NUM_CH-1 to 0.
  - SYS_leds <= fmt(ch_data[cur_ch]) every cycle (live data).
  - SYS_output_sel is ignored.
- Freeze mode (10), two states:
  - ARMED: behaves as direct mode. On freeze_trig=1: snapshot <= ch_data[SYS_output_sel], frozen<=1, cur_ch<=SYS_output_sel, state->HELD.
  - HELD: SYS_leds <= fmt(snapshot); cur_ch held; freeze_trig ignored.
  - Leaving mode 10 from either state: frozen<=0, state->ARMED, snapshot retained but unused.
  - A mode change in the same cycle as freeze_trig: the new mode wins, so no capture occurs.
- Mode switches take effect on the first edge at which the new mode is sampled. The tick generator runs continuously in all modes.
- Simultaneous tick and scan wrap: the index update and the CLK_led toggle happen on the same edge.

Optional Feature:
- Macro: LED_CH_TAG_EN.
- Defined: SYS_leds[LED_W-1 -: SEL_W] = cur_ch next-state (the index of the channel shown); the lower LED_W-SEL_W bits = fmt(word)[LED_W-SEL_W-1:0]. Applies in all modes, including HELD.
- Undefined: SYS_leds carries only fmt(word); no index bits.

Test Plan (NUM_CH=8, DATA_W=32, LED_W=27, DIV_CNT=4, SCAN_HOLD=2; channel k word = 32'hA000_0000+k):
- Reset: hold SYS_reset=0 for 3 edges -> SYS_leds=0, CLK_led=0, cur_ch=0, frozen=0. Release -> CLK_led first rises 4 cycles later and toggles every 4 cycles thereafter.
- Direct: mode=00, SYS_output_sel=2 -> after 1 edge SYS_leds=27'h000_0002 and cur_ch=2. Change ch_data[2] to 32'h07FF_FFFF -> SYS_leds=27'h7FF_FFFF 1 cycle later.
- Scan wrap: mode=01 starting at cur_ch=6 -> cur_ch goes 7 after 2 ticks (8 cycles), then 0 after a further 8 cycles. SYS_leds tracks the live word of each channel.
- Freeze: mode=10, sel=3, pulse freeze_trig, then change ch_data[3] -> SYS_leds stays 27'h000_0003 and frozen=1. A second freeze_trig has no effect. Set mode=00 -> frozen=0 next edge and LEDs are live again.
- Mid-operation reset during scan at cur_ch=5 with SYS_reset=0 for 1 edge -> all outputs 0. Scanning restarts at channel 0 once reset is released.
- LED_CH_TAG_EN defined, direct sel=5 -> SYS_leds[26:24]=3'b101 and SYS_leds[23:0]=24'h000005.
